// File: rtl/serdes_ser_tx.sv
// Transmit half of the V1 source-synchronous serdes: takes bytes over a req/gnt handshake and
// shifts them out as a gated serial clock plus data line.
module serdes_ser_tx #(
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_gnt,
    output logic       ser_clk,
    output logic       ser_data,
    output logic       busy
);

    localparam int unsigned     DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_t;

    state_t          state;
    logic [DivW-1:0] div_cnt;
    logic            phase;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;

    logic half_done;
    logic byte_done;

    function automatic logic first_bit(input logic [7:0] b);
        return MSB_FIRST ? b[7] : b[0];
    endfunction

    // The bit on ser_data is always the leading bit of shreg, so advancing drops it.
    function automatic logic [7:0] advance(input logic [7:0] b);
        return MSB_FIRST ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
    endfunction

    always_comb begin
        half_done = (div_cnt == DivMax);
        byte_done = half_done && phase && (bit_cnt == 3'd7);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            div_cnt  <= '0;
            phase    <= 1'b0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            tx_gnt   <= 1'b0;
            ser_clk  <= 1'b0;
            ser_data <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tx_gnt <= 1'b0;
            unique case (state)
                StIdle: begin
                    ser_clk <= 1'b0;
                    if (tx_req) begin
                        shreg    <= tx_data;
                        tx_gnt   <= 1'b1;
                        busy     <= 1'b1;
                        ser_data <= first_bit(tx_data);
                        phase    <= 1'b0;
                        bit_cnt  <= 3'd0;
                        div_cnt  <= '0;
                        state    <= StShift;
                    end else begin
                        ser_data <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                StShift: begin
                    if (!half_done) begin
                        div_cnt <= div_cnt + DivW'(1);
                    end else if (!phase) begin
                        ser_clk <= 1'b1;
                        phase   <= 1'b1;
                        div_cnt <= '0;
                    end else if (!byte_done) begin
                        ser_clk  <= 1'b0;
                        shreg    <= advance(shreg);
                        ser_data <= first_bit(advance(shreg));
                        bit_cnt  <= bit_cnt + 3'd1;
                        phase    <= 1'b0;
                        div_cnt  <= '0;
                    end else begin
                        // End of byte: chain the next byte with no clock gap, or go idle.
                        ser_clk <= 1'b0;
                        phase   <= 1'b0;
                        bit_cnt <= 3'd0;
                        div_cnt <= '0;
                        if (tx_req) begin
                            shreg    <= tx_data;
                            tx_gnt   <= 1'b1;
                            ser_data <= first_bit(tx_data);
                        end else begin
                            shreg    <= 8'h00;
                            ser_data <= 1'b0;
                            busy     <= 1'b0;
                            state    <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_ser_tx.sv
// Directed bench for serdes_ser_tx: three instances cover CLK_DIV=2/1/3 and both bit orders.
module tb_serdes_ser_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a   [3];
    logic       tx_req_a  [3];
    logic [7:0] tx_data_a [3];
    logic       tx_gnt_w  [3];
    logic       ser_clk_w [3];
    logic       ser_data_w[3];
    logic       busy_w    [3];

    serdes_ser_tx #(.CLK_DIV(2), .MSB_FIRST(1'b1)) u_div2 (
        .clk(clk), .reset(reset_a[0]), .tx_req(tx_req_a[0]), .tx_data(tx_data_a[0]),
        .tx_gnt(tx_gnt_w[0]), .ser_clk(ser_clk_w[0]), .ser_data(ser_data_w[0]),
        .busy(busy_w[0])
    );
    serdes_ser_tx #(.CLK_DIV(1), .MSB_FIRST(1'b1)) u_div1 (
        .clk(clk), .reset(reset_a[1]), .tx_req(tx_req_a[1]), .tx_data(tx_data_a[1]),
        .tx_gnt(tx_gnt_w[1]), .ser_clk(ser_clk_w[1]), .ser_data(ser_data_w[1]),
        .busy(busy_w[1])
    );
    serdes_ser_tx #(.CLK_DIV(3), .MSB_FIRST(1'b0)) u_div3 (
        .clk(clk), .reset(reset_a[2]), .tx_req(tx_req_a[2]), .tx_data(tx_data_a[2]),
        .tx_gnt(tx_gnt_w[2]), .ser_clk(ser_clk_w[2]), .ser_data(ser_data_w[2]),
        .busy(busy_w[2])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor state; clearing is requested by bumping clr_gen so each variable has one writer.
    int          clr_gen [3] = '{0, 0, 0};
    int          seen_gen[3] = '{0, 0, 0};
    int          cyc = 0;
    int          rises[3], gnts[3], busy_n[3], glitch[3], act[3], dbl_gnt[3];
    int          run[3], hi_min[3], hi_max[3], lo_min[3], lo_max[3];
    int          t_gnt_first[3], t_gnt_last[3], gnt_gap[3], t_rise_first[3];
    logic [15:0] bits[3];
    logic        prev_clk[3], prev_data[3], prev_gnt[3], seen_high[3];

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (seen_gen[d] != clr_gen[d]) begin
                seen_gen[d]     = clr_gen[d];
                rises[d]        = 0;
                gnts[d]         = 0;
                busy_n[d]       = 0;
                glitch[d]       = 0;
                act[d]          = 0;
                dbl_gnt[d]      = 0;
                hi_min[d]       = 9999;
                hi_max[d]       = 0;
                lo_min[d]       = 9999;
                lo_max[d]       = 0;
                t_gnt_first[d]  = -1;
                t_gnt_last[d]   = -1;
                gnt_gap[d]      = -1;
                t_rise_first[d] = -1;
                bits[d]         = 16'h0;
                seen_high[d]    = 1'b0;
                run[d]          = 0;
            end
            if (ser_clk_w[d] === prev_clk[d]) begin
                run[d]++;
            end else begin
                if (prev_clk[d] === 1'b1) begin
                    if (run[d] < hi_min[d]) hi_min[d] = run[d];
                    if (run[d] > hi_max[d]) hi_max[d] = run[d];
                end else if (seen_high[d]) begin
                    if (run[d] < lo_min[d]) lo_min[d] = run[d];
                    if (run[d] > lo_max[d]) lo_max[d] = run[d];
                end
                run[d] = 1;
            end
            if (ser_clk_w[d] === 1'b1 && prev_clk[d] !== 1'b1) begin
                rises[d]++;
                seen_high[d] = 1'b1;
                bits[d] = {bits[d][14:0], ser_data_w[d]};
                if (t_rise_first[d] < 0) t_rise_first[d] = cyc;
            end
            if (ser_clk_w[d] === 1'b1 && prev_clk[d] === 1'b1 && ser_data_w[d] !== prev_data[d])
                glitch[d]++;
            if (tx_gnt_w[d] === 1'b1) begin
                gnts[d]++;
                if (prev_gnt[d] === 1'b1) dbl_gnt[d]++;
                if (t_gnt_last[d] >= 0) gnt_gap[d] = cyc - t_gnt_last[d];
                if (t_gnt_first[d] < 0) t_gnt_first[d] = cyc;
                t_gnt_last[d] = cyc;
            end
            if (busy_w[d] === 1'b1) busy_n[d]++;
            if ({tx_gnt_w[d], ser_clk_w[d], ser_data_w[d], busy_w[d]} !== 4'b0000) act[d]++;
            prev_clk[d]  = ser_clk_w[d];
            prev_data[d] = ser_data_w[d];
            prev_gnt[d]  = tx_gnt_w[d];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr(input int d);
        clr_gen[d] = clr_gen[d] + 1;
    endtask

    task automatic wait_gnt(input int d, input int limit, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(posedge clk);
            #1;
            if (tx_gnt_w[d] === 1'b1) hit = 1'b1;
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic send_one(input int d, input logic [7:0] b, input int tail);
        clr(d);
        tx_data_a[d] = b;
        tx_req_a[d]  = 1'b1;
        wait_gnt(d, 10, "gnt_wait");
        tx_req_a[d] = 1'b0;
        step(tail);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            reset_a[d]   = 1'b1;
            tx_req_a[d]  = 1'b0;
            tx_data_a[d] = 8'h00;
        end
        step(3);
        check("rst_gnt", 32'(tx_gnt_w[0]), 32'd0);
        check("rst_sclk", 32'(ser_clk_w[0]), 32'd0);
        check("rst_sdata", 32'(ser_data_w[0]), 32'd0);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        for (int d = 0; d < 3; d++) reset_a[d] = 1'b0;
        step(2);

        // Single byte 0xA5, CLK_DIV=2
        send_one(0, 8'hA5, 40);
        check("t1_rises", 32'(rises[0]), 32'd8);
        check("t1_bits", 32'(bits[0][7:0]), 32'hA5);
        check("t1_gnts", 32'(gnts[0]), 32'd1);
        check("t1_busy", 32'(busy_n[0]), 32'd32);
        check("t1_lat", 32'(t_rise_first[0] - t_gnt_first[0]), 32'd2);
        check("t1_hi", 32'({hi_min[0][15:0], hi_max[0][15:0]}), 32'h0002_0002);
        check("t1_lo", 32'({lo_min[0][15:0], lo_max[0][15:0]}), 32'h0002_0002);
        check("t1_glitch", 32'(glitch[0]), 32'd0);
        check("t1_end", 32'({ser_clk_w[0], ser_data_w[0], busy_w[0]}), 32'd0);

        // Back-to-back 0x3C, 0xFF with tx_req held
        clr(0);
        tx_data_a[0] = 8'h3C;
        tx_req_a[0]  = 1'b1;
        wait_gnt(0, 10, "t2_gnt1");
        tx_data_a[0] = 8'hFF;
        wait_gnt(0, 40, "t2_gnt2");
        tx_req_a[0] = 1'b0;
        step(40);
        check("t2_rises", 32'(rises[0]), 32'd16);
        check("t2_bits", 32'(bits[0]), 32'h3CFF);
        check("t2_gnts", 32'(gnts[0]), 32'd2);
        check("t2_gap", 32'(gnt_gap[0]), 32'd32);
        check("t2_nogap", 32'(lo_max[0]), 32'd2);
        check("t2_dblgnt", 32'(dbl_gnt[0]), 32'd0);
        check("t2_busy", 32'(busy_n[0]), 32'd64);

        // Reset after the third rise of 0x81, then a fresh 0x55
        clr(0);
        tx_data_a[0] = 8'h81;
        tx_req_a[0]  = 1'b1;
        wait_gnt(0, 10, "t3_gnt1");
        tx_req_a[0] = 1'b0;
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                step(1);
                if (rises[0] >= 3) hit = 1'b1;
            end
            check("t3_3rises", 32'(hit), 32'd1);
        end
        reset_a[0] = 1'b1;
        #1;
        check("t3_rst_now", 32'({tx_gnt_w[0], ser_clk_w[0], ser_data_w[0], busy_w[0]}), 32'd0);
        tx_req_a[0]  = 1'b1;
        tx_data_a[0] = 8'h55;
        clr(0);
        step(4);
        check("t3_rst_hold", 32'(act[0]), 32'd0);
        reset_a[0] = 1'b0;
        wait_gnt(0, 10, "t3_gnt2");
        tx_req_a[0] = 1'b0;
        step(40);
        check("t3_rises", 32'(rises[0]), 32'd8);
        check("t3_bits", 32'(bits[0]), 32'h0055);
        check("t3_gnts", 32'(gnts[0]), 32'd1);

        // CLK_DIV=1, byte 0x01
        send_one(1, 8'h01, 24);
        check("t4_rises", 32'(rises[1]), 32'd8);
        check("t4_bits", 32'(bits[1][7:0]), 32'h01);
        check("t4_busy", 32'(busy_n[1]), 32'd16);
        check("t4_hi", 32'({hi_min[1][15:0], hi_max[1][15:0]}), 32'h0001_0001);
        check("t4_lo", 32'({lo_min[1][15:0], lo_max[1][15:0]}), 32'h0001_0001);

        // LSB first, CLK_DIV=3, byte 0x01: first bit out is 1
        send_one(2, 8'h01, 60);
        check("t5_rises", 32'(rises[2]), 32'd8);
        check("t5_bits", 32'(bits[2][7:0]), 32'h80);
        check("t5_busy", 32'(busy_n[2]), 32'd48);
        check("t5_lat", 32'(t_rise_first[2] - t_gnt_first[2]), 32'd3);
        check("t5_hi", 32'({hi_min[2][15:0], hi_max[2][15:0]}), 32'h0003_0003);
        check("t5_lo", 32'({lo_min[2][15:0], lo_max[2][15:0]}), 32'h0003_0003);

        // Idle stability after reset
        reset_a[0] = 1'b1;
        step(2);
        reset_a[0] = 1'b0;
        clr(0);
        step(100);
        check("t6_idle", 32'(act[0]), 32'd0);
        check("t6_gnts", 32'(gnts[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serdes_ser_tx.md
Name: serdes_ser_tx

Overview:
Transmit half of the V1 source-synchronous serdes. It takes bytes from the parallel client side using the tx_req/tx_gnt/tx_data handshake of serdes_par_if. It drives them onto the serial pins as a gated, source-synchronous clock plus a data line, matching serdes_ser_if tx_clk/tx_data. The serial clock toggles only while a byte is being shifted, which keeps idle power low. The block sits between the serdes_par_if serdes modport and the serdes_ser_if serdes modport.

Parameters:
CLK_DIV, 2, system-clock cycles per serial half-period; legal range >= 1; one byte takes 16*CLK_DIV cycles.
MSB_FIRST, 1, 1 = bit 7 is shifted first; 0 = bit 0 is shifted first.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
tx_req  input  1  client has a byte on tx_data; held until tx_gnt is seen
tx_data  input  8  byte to send; must be stable while tx_req=1
tx_gnt  output  1  one-cycle pulse: tx_data captured this cycle
ser_clk  output  1  serial clock (to tx_clk); receiver samples ser_data on its rising edge
ser_data  output  1  serial data (to tx_data); changes only while ser_clk=0
busy  output  1  1 while a byte is being shifted

Behaviour:
- All outputs are registered.
- Reset is asynchronous. While reset=1: tx_gnt=0, ser_clk=0, ser_data=0, busy=0, state=IDLE, all counters and the shift register cleared.
- Reset mid-byte: the partial byte is abandoned. ser_clk drops to 0 immediately and no further edges are produced. The client is not re-granted; after release the block starts from IDLE.
- States: IDLE and SHIFT.
- Internal counters:
  - div_cnt: 0..CLK_DIV-1.
  - phase: 0 = low half, 1 = high half.
  - bit_cnt: 0..7.
  - shift register: 8 bits.
- IDLE, tx_req=0: all outputs 0.
- IDLE, tx_req=1 at edge N:
  - capture tx_data into the shift register;
  - tx_gnt=1 for exactly the cycle after edge N;
  - busy=1;
  - ser_data = first bit (bit 7 if MSB_FIRST, else bit 0);
  - ser_clk=0, phase=0, bit_cnt=0, div_cnt=0;
  - go to SHIFT.
- SHIFT: div_cnt counts each cycle. When div_cnt = CLK_DIV-1 and phase=0: ser_clk<=1, phase<=1, div_cnt<=0.
- SHIFT: when div_cnt = CLK_DIV-1, phase=1 and bit_cnt<7: ser_clk<=0, present the next bit on ser_data, bit_cnt++, phase<=0, div_cnt<=0.
- End of byte (div_cnt=CLK_DIV-1, phase=1, bit_cnt=7): ser_clk<=0, then tx_req is sampled.
  - tx_req=1: capture a new byte, pulse tx_gnt, present its first bit, stay in SHIFT with counters zeroed. The serial clock runs back-to-back with no gap.
  - tx_req=0: go to IDLE with ser_data<=0 and busy<=0.
- tx_req is ignored in SHIFT except at the end-of-byte instant. The 16*CLK_DIV-cycle spacing between tx_gnt pulses gives the client time to update tx_data/tx_req after a grant.
- Timing per byte: exactly 8 ser_clk rising edges. The first rising edge occurs CLK_DIV cycles after the tx_gnt cycle begins. ser_clk high and low halves are each exactly CLK_DIV cycles.
- ser_data is stable from CLK_DIV cycles before each ser_clk rising edge to CLK_DIV cycles after it.
- tx_gnt is never asserted in two consecutive cycles, and never without a prior tx_req=1 sample.
- A tx_req dropped before it is granted is a client protocol violation. Behaviour is undefined only in that the byte may or may not be sent; the FSM must still return to IDLE cleanly.

Test Plan:
1. CLK_DIV=2, single byte 0xA5, then tx_req=0 after tx_gnt -> exactly one tx_gnt pulse; 8 ser_clk rises; ser_data sampled at the rises = 1,0,1,0,0,1,0,1; busy high for 32 cycles; then ser_clk=ser_data=0.
2. CLK_DIV=2, back-to-back 0x3C then 0xFF with tx_req held -> 16 contiguous rises with no gap; sampled bits 00111100 11111111; two tx_gnt pulses 32 cycles apart.
3. CLK_DIV=2, byte 0x81; assert reset after the 3rd rise; release reset with tx_req=1 and tx_data=0x55 -> outputs 0 during reset; fresh 0x55 frame of 8 rises; no rise left over from 0x81.
4. CLK_DIV=1, byte 0x01 -> byte completes in 16 cycles; ser_clk period 2 cycles; last sampled bit 1, all others 0.
5. MSB_FIRST=0, CLK_DIV=3, byte 0x01 -> first sampled bit 1, remaining 7 bits 0; half-periods of 3 cycles measured.
6. Idle stability: reset, then tx_req=0 for 100 cycles -> ser_clk, ser_data, tx_gnt and busy remain 0 throughout.
